// File: rtl/ysyx_25020047_lsu_pkg.sv
// Shared encodings for the load/store unit: memory op codes, FSM states,
// and byte-strobe base patterns that get shifted into lane position.
package ysyx_25020047_lsu_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Combinational lane logic: store strobes and replication, load extraction
// and extension, and alignment checking for a given op and byte lane.
module ysyx_25020047_lsu_align
  import ysyx_25020047_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        is_mem,
  output logic        is_store
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (lane)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wstrb      = '0;
    wdata_rep  = wdata;
    load_data  = '0;
    misaligned = 1'b0;
    is_mem     = 1'b1;
    is_store   = 1'b0;
    case (op)
      OP_LB:  load_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU: load_data = {24'b0, byte_v};
      OP_LH: begin
        misaligned = lane[0];
        load_data  = {{16{half_v[15]}}, half_v};
      end
      OP_LHU: begin
        misaligned = lane[0];
        load_data  = {16'b0, half_v};
      end
      OP_LW: begin
        misaligned = (lane != 2'd0);
        load_data  = rdata;
      end
      OP_SB: begin
        is_store  = 1'b1;
        wstrb     = STRB_BYTE << lane;
        wdata_rep = {4{wdata[7:0]}};
      end
      OP_SH: begin
        is_store   = 1'b1;
        misaligned = lane[0];
        wstrb      = STRB_HALF << lane;
        wdata_rep  = {2{wdata[15:0]}};
      end
      OP_SW: begin
        is_store   = 1'b1;
        misaligned = (lane != 2'd0);
        wstrb      = STRB_WORD;
      end
      default: is_mem = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one valid/ready bus transaction per op, with timeout,
// returning extended load data (or a passthrough value) to writeback.
module ysyx_25020047_lsu
  import ysyx_25020047_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_err
);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [1:0]       lane_q;

  logic [3:0]  op_sel;
  logic [1:0]  lane_sel;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_misaligned;
  logic        al_is_mem;
  logic        al_is_store;
  logic        accept;
  logic        timeout;

  // One aligner serves both phases: the incoming op while idle, the latched op afterwards.
  assign op_sel   = (state_q == S_IDLE) ? in_op : op_q;
  assign lane_sel = (state_q == S_IDLE) ? in_addr[1:0] : lane_q;

  ysyx_25020047_lsu_align u_align (
    .op         (op_sel),
    .lane       (lane_sel),
    .wdata      (in_wdata),
    .rdata      (mem_resp_rdata),
    .wstrb      (al_wstrb),
    .wdata_rep  (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned),
    .is_mem     (al_is_mem),
    .is_store   (al_is_store)
  );

  assign in_ready      = (state_q == S_IDLE) && !rst;
  assign out_valid     = (state_q == S_DONE);
  assign mem_req_valid = (state_q == S_REQ);
  assign accept        = in_valid && in_ready;
  assign timeout       = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (!al_is_mem || al_misaligned) ? S_DONE : S_REQ;
      S_REQ:  if (mem_req_ready) state_d = S_WAIT;
      S_WAIT: if (mem_resp_valid || timeout) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      lane_q        <= '0;
      out_rdata     <= '0;
      out_err       <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (accept) begin
          op_q   <= in_op;
          lane_q <= in_addr[1:0];
          if (!al_is_mem) begin
            out_rdata <= in_addr;
            out_err   <= 1'b0;
          end else if (al_misaligned) begin
            out_rdata <= '0;
            out_err   <= 1'b1;
          end else begin
            mem_req_wen   <= al_is_store;
            mem_req_addr  <= {in_addr[31:2], 2'b00};
            mem_req_wdata <= al_wdata;
            mem_req_wstrb <= al_wstrb;
          end
        end
        S_REQ: if (mem_req_ready) cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A response in the final timeout cycle still counts as a response.
          if (mem_resp_valid) begin
            out_err   <= mem_resp_err;
            out_rdata <= (al_is_store || mem_resp_err) ? '0 : al_load;
          end else if (timeout) begin
            out_err   <= 1'b1;
            out_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Randomized and directed bench for the load/store unit against a
// behavioural model of the op/lane/extension rules.
module tb_ysyx_25020047_lsu;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  ysyx_25020047_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rdata      (out_rdata),
    .out_err        (out_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .mem_resp_err   (mem_resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic bit m_is_mem(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic bit m_is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic bit m_misal(input logic [3:0] op, input logic [31:0] addr);
    if (op == 4'd2 || op == 4'd5 || op == 4'd7) return (addr % 2) != 0;
    if (op == 4'd3 || op == 4'd8) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    int          v;
    b = 8'(w >> (8 * (addr % 4)));
    h = 16'(w >> (16 * ((addr % 4) / 2)));
    case (op)
      4'd1:    v = int'($signed(b));
      4'd2:    v = int'($signed(h));
      4'd4:    v = int'(b);
      4'd5:    v = int'(h);
      default: v = int'(w);
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] w);
    if (op == 4'd6) return {4{w[7:0]}};
    if (op == 4'd7) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [3:0] op, input logic [31:0] addr);
    if (op == 4'd6) return 4'(1 << (addr % 4));
    if (op == 4'd7) return 4'(3 << (addr % 4));
    if (op == 4'd8) return 4'hF;
    return 4'h0;
  endfunction

  // resp_dly < 0 means the bus never answers.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] resp, input logic rerr,
                        input int req_dly, input int resp_dly, input int ord_dly);
    logic [31:0] e_rdata;
    logic        e_err;
    int          guard;
    guard = 0;
    while (!in_ready && guard < 10) begin
      tick;
      guard++;
    end
    check("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata;
    tick;
    in_valid = 1'b0; in_op = 4'($urandom); in_addr = $urandom; in_wdata = $urandom;
    if (!m_is_mem(op)) begin
      e_rdata = addr; e_err = 1'b0;
    end else if (m_misal(op, addr)) begin
      e_rdata = '0; e_err = 1'b1;
    end else begin
      for (int i = 0; i <= req_dly; i++) begin
        if (i > 0) tick;
        check("req_valid", 32'(mem_req_valid), 1);
        check("req_wen", 32'(mem_req_wen), 32'(m_is_store(op)));
        check("req_addr", mem_req_addr, {addr[31:2], 2'b00});
        check("req_wstrb", 32'(mem_req_wstrb), 32'(m_wstrb(op, addr)));
        if (m_is_store(op)) check("req_wdata", mem_req_wdata, m_wdata(op, wdata));
        check("in_ready_req", 32'(in_ready), 0);
      end
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      check("req_drop", 32'(mem_req_valid), 0);
      if (resp_dly < 0) begin
        guard = 0;
        while (!out_valid && guard < int'(TO) + 5) begin
          tick;
          guard++;
        end
        check("timeout_cycles", 32'(guard == int'(TO) || guard == int'(TO) + 1), 1);
        e_rdata = '0; e_err = 1'b1;
      end else begin
        for (int i = 0; i < resp_dly; i++) begin
          mem_resp_rdata = $urandom; mem_resp_err = 1'($urandom);
          tick;
          check("wait_no_valid", 32'(out_valid), 0);
        end
        mem_resp_valid = 1'b1; mem_resp_rdata = resp; mem_resp_err = rerr;
        tick;
        mem_resp_valid = 1'b0; mem_resp_rdata = $urandom; mem_resp_err = 1'($urandom);
        e_err   = rerr;
        e_rdata = (m_is_store(op) || rerr) ? 32'h0 : m_load(op, addr, resp);
      end
    end
    check("out_valid", 32'(out_valid), 1);
    check("out_rdata", out_rdata, e_rdata);
    check("out_err", 32'(out_err), 32'(e_err));
    check("in_ready_done", 32'(in_ready), 0);
    check("req_valid_done", 32'(mem_req_valid), 0);
    for (int i = 0; i < ord_dly; i++) begin
      tick;
      check("hold_valid", 32'(out_valid), 1);
      check("hold_rdata", out_rdata, e_rdata);
      check("hold_err", 32'(out_err), 32'(e_err));
      check("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 0);
    check("in_ready_after", 32'(in_ready), 1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0;
    out_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_rdata = '0; mem_resp_err = 1'b0;
    tick;
    tick;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_req_valid", 32'(mem_req_valid), 0);
    check("rst_out_rdata", out_rdata, 0);
    check("rst_out_err", 32'(out_err), 0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(in_ready), 1);

    run_op(4'd3, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0, 0);
    run_op(4'd1, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1'b0, 0, 0, 0);
    check("lb_const", out_rdata, 32'hFFFF_FF80);
    run_op(4'd4, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1'b0, 0, 0, 0);
    check("lbu_const", out_rdata, 32'h0000_0080);
    run_op(4'd7, 32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555, 1'b0, 0, 0, 0);
    run_op(4'd3, 32'h8000_0002, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    run_op(4'd3, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 1'b0, 5, 0, 3);
    run_op(4'd8, 32'h8000_0020, 32'hA5A5_0F0F, 32'h0, 1'b0, 2, 1, 1);
    run_op(4'd3, 32'h8000_0030, 32'h0, 32'h0, 1'b0, 0, -1, 0);
    run_op(4'd2, 32'h8000_0042, 32'h0, 32'h1122_8344, 1'b0, 0, int'(TO) - 1, 0);
    run_op(4'd5, 32'h8000_0040, 32'h0, 32'h1234_5678, 1'b1, 1, 2, 0);
    run_op(4'd12, 32'h7777_1235, 32'h0, 32'h0, 1'b0, 0, 0, 1);
    run_op(4'd0, 32'h5555_AAAA, 32'h0, 32'h0, 1'b0, 0, 0, 0);

    in_valid = 1'b1; in_op = 4'd8; in_addr = 32'h0000_0044; in_wdata = 32'h1357_9BDF;
    tick;
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 0);
    tick;
    rst = 1'b0;
    #1;
    check("rst_mid_req_valid", 32'(mem_req_valid), 0);
    check("rst_mid_out_valid", 32'(out_valid), 0);
    check("rst_mid_out_rdata", out_rdata, 0);
    check("rst_mid_out_err", 32'(out_err), 0);
    check("rst_mid_req_addr", mem_req_addr, 0);
    check("rst_mid_req_wdata", mem_req_wdata, 0);
    check("rst_mid_req_wstrb", 32'(mem_req_wstrb), 0);
    check("rst_mid_in_ready_rel", 32'(in_ready), 1);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0_BAD0; mem_resp_err = 1'b1;
    tick;
    mem_resp_valid = 1'b0;
    check("stale_out_valid", 32'(out_valid), 0);
    check("stale_out_rdata", out_rdata, 0);
    check("stale_out_err", 32'(out_err), 0);
    check("stale_in_ready", 32'(in_ready), 1);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      run_op(4'($urandom_range(0, 15)), a, $urandom, $urandom, ($urandom_range(0, 7) == 0),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25020047_lsu.md
Name: ysyx_25020047_lsu

Overview:
Load/store unit directly downstream of the execute unit. It consumes the EXU effective address (`result`), the store data (`rdata2`) and a decoded memory op. It runs one multi-cycle transaction on a valid/ready memory bus and returns load data, aligned and extended, to writeback. Ops with no memory access pass the EXU result through in one cycle. This lets the core move off DPI single-cycle memory onto a bus with variable latency.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before the transaction is flagged as an error
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  EXU presents an op
in_ready  out  1  LSU can accept an op
in_op  in  4  memory op: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; other codes are treated as NONE
in_addr  in  32  EXU result (effective address, or passthrough value)
in_wdata  in  32  store data (rs2)
out_valid  out  1  result available to writeback
out_ready  in  1  writeback accepts the result
out_rdata  out  32  load data (extended), passthrough value for NONE, 0 for stores
out_err  out  1  misaligned access or bus timeout/error
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_wen  out  1  1=store, 0=load
mem_req_addr  out  32  word-aligned address {in_addr[31:2],2'b00}
mem_req_wdata  out  32  lane-replicated store data
mem_req_wstrb  out  4  byte strobes; 0 for loads
mem_resp_valid  in  1  bus response valid; always accepted (no resp ready)
mem_resp_rdata  in  32  full word read data
mem_resp_err  in  1  bus error

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (rst high at an edge):
  - state goes to IDLE and the timeout counter clears.
  - All registered outputs go to 0: out_valid, out_rdata, out_err, mem_req_*.
  - in_ready = (state==IDLE) && !rst.
- IDLE:
  - Accept when in_valid && in_ready. Latch op, addr, wdata.
  - NONE op: go to DONE with out_rdata=in_addr, out_err=0.
  - Misaligned op (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0): go to DONE with out_rdata=0, out_err=1, and issue no bus request.
  - Any other op: go to REQ.
- REQ:
  - mem_req_valid=1. Address, wen, wdata and wstrb are held stable until mem_req_ready.
  - On handshake: go to WAIT and clear the counter.
- WAIT:
  - Counter increments each cycle.
  - On mem_resp_valid: go to DONE with out_err=mem_resp_err.
  - Loads: out_rdata = extended data, or 0 if mem_resp_err. Stores: out_rdata=0.
  - If the counter reaches TIMEOUT_CYCLES without a response: go to DONE with out_err=1, out_rdata=0.
- DONE:
  - out_valid=1, with data and err held stable.
  - On out_ready: go to IDLE. The next op may be accepted in the following cycle (no same-cycle turnaround).
- Bus contract:
  - The response arrives at least one cycle after the request handshake.
  - mem_resp_valid outside WAIT is ignored, including a stale response after reset.
- Lane select, with lane=addr[1:0]:
  - LB/LBU: byte at bits 8*lane+7..8*lane, sign- or zero-extended.
  - LH/LHU: half at bits 16*addr[1]+15.., sign- or zero-extended.
  - LW: full word.
- Stores:
  - SB: wdata={4{wdata[7:0]}}, wstrb=4'b0001<<lane.
  - SH: wdata={2{wdata[15:0]}}, wstrb=4'b0011<<lane.
  - SW: wdata=wdata, wstrb=4'hF.
- Latency:
  - NONE or misaligned: out_valid in the cycle after accept.
  - Bus op with ready=1 and a 1-cycle response: accept at T, request at T+1, response at T+2, out_valid at T+3.
- Reset mid-transaction: the transaction is abandoned and mem_req_valid is low from the next cycle. Memory side effects of an already-handshaken store are not undone.
- Simultaneous mem_resp_valid and timeout in the same cycle: the response wins.

Decomposition:
- Package ysyx_25020047_lsu_pkg: mem_op encoding constants, FSM state enum, lane helper constants.
- Sub-module ysyx_25020047_lsu_align (combinational): op + addr[1:0] + wdata/rdata → wstrb, replicated wdata, extended load data, misaligned flag.

Test Plan:
- LW at addr 0x80000004, bus ready=1, resp 0xDEADBEEF after 1 cycle → out_valid at T+3, out_rdata=0xDEADBEEF, err=0.
- LB at 0x80000003, resp 0x80FFFFFF → out_rdata=0xFFFFFF80. Same with LBU → 0x00000080.
- SH at 0x80000002, wdata 0x1234ABCD → mem_req_wdata=0xABCDABCD, wstrb=4'b1100, addr=0x80000000, out_rdata=0.
- LW at 0x80000002 → no mem_req_valid, out_valid next cycle, out_err=1, out_rdata=0.
- mem_req_ready low 5 cycles, then out_ready low 3 cycles in DONE → request and result fields stable throughout; in_ready=0 until the DONE handshake.
- No response for TIMEOUT_CYCLES → out_err=1. rst asserted in WAIT, then a late mem_resp_valid → IDLE, outputs 0, response ignored.
